// File: rtl/atm_account_server.sv
// ----------------------------------------------------------------------------
// atm_account_server
//
// Bank-side responder for ATM transaction requests. Holds a small account
// table (PIN, balance, consecutive bad-PIN count, lock flag) and serves one
// request at a time. A request is accepted in IDLE, evaluated in EXEC, and
// the registered response is held in RESP until the ATM takes it.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | req_ready high, waiting for a request
// EXEC  | one cycle: checks evaluated, account table updated at its end
// RESP  | rsp_valid high, status/balance held until rsp_ready
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready              request handshake
//   req_op, req_acct, req_pin,
//   req_amount                       request payload (captured on accept)
//   rsp_valid/rsp_ready              response handshake
//   rsp_status, rsp_balance          registered response payload
//   unlock, unlock_acct              admin pulse clearing an account lock
// ----------------------------------------------------------------------------
module atm_account_server #(
    parameter int               NUM_ACCTS    = 4,
    parameter int               ACCT_W       = 2,
    parameter int               BAL_W        = 8,
    parameter int               PIN_W        = 4,
    parameter int               MAX_TRIES    = 3,
    parameter int               INIT_BALANCE = 50,
    parameter logic [PIN_W-1:0] DEFAULT_PIN  = 4'b1101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ACCT_W-1:0] req_acct,
    input  logic [PIN_W-1:0]  req_pin,
    input  logic [BAL_W-1:0]  req_amount,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_status,
    output logic [BAL_W-1:0]  rsp_balance,
    input  logic              unlock,
    input  logic [ACCT_W-1:0] unlock_acct
);

    localparam int FAIL_W = $clog2(MAX_TRIES + 1);

    localparam logic [1:0] OP_WITHDRAW = 2'b00;
    localparam logic [1:0] OP_DEPOSIT  = 2'b01;

    localparam logic [2:0] STS_OK       = 3'd0;
    localparam logic [2:0] STS_BAD_PIN  = 3'd1;
    localparam logic [2:0] STS_LOCKED   = 3'd2;
    localparam logic [2:0] STS_INSUFF   = 3'd3;
    localparam logic [2:0] STS_OVERFLOW = 3'd4;
    localparam logic [2:0] STS_BAD_ACCT = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Captured request
    logic [1:0]        op_q;
    logic [ACCT_W-1:0] acct_q;
    logic [PIN_W-1:0]  pin_q;
    logic [BAL_W-1:0]  amt_q;

    // Account table
    logic [BAL_W-1:0]  bal_tbl_q  [NUM_ACCTS];
    logic [PIN_W-1:0]  pin_tbl_q  [NUM_ACCTS];
    logic [FAIL_W-1:0] fail_tbl_q [NUM_ACCTS];
    logic              lock_tbl_q [NUM_ACCTS];

    // Response registers
    logic [2:0]        rsp_status_q, rsp_status_d;
    logic [BAL_W-1:0]  rsp_balance_q, rsp_balance_d;

    // EXEC evaluation results
    logic              acct_ok;
    logic [BAL_W-1:0]  cur_bal;
    logic [PIN_W-1:0]  cur_pin;
    logic [FAIL_W-1:0] cur_fail;
    logic              cur_lock;
    logic [BAL_W:0]    dep_sum;
    logic [FAIL_W-1:0] fail_inc;
    logic [BAL_W-1:0]  bal_d;
    logic [FAIL_W-1:0] fail_d;
    logic              lock_d;

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_status  = rsp_status_q;
    assign rsp_balance = rsp_balance_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Account lookup; out-of-range indices read as an empty entry and are
    // never written.
    always_comb begin
        acct_ok  = (int'(acct_q) < NUM_ACCTS);
        cur_bal  = '0;
        cur_pin  = '0;
        cur_fail = '0;
        cur_lock = 1'b0;
        if (acct_ok) begin
            cur_bal  = bal_tbl_q[acct_q];
            cur_pin  = pin_tbl_q[acct_q];
            cur_fail = fail_tbl_q[acct_q];
            cur_lock = lock_tbl_q[acct_q];
        end
    end

    // Transaction evaluation in priority order
    always_comb begin
        // One extra bit so a deposit that exceeds the balance range is seen
        // as overflow instead of wrapping.
        dep_sum       = {1'b0, cur_bal} + {1'b0, amt_q};
        fail_inc      = cur_fail + FAIL_W'(1);
        bal_d         = cur_bal;
        fail_d        = cur_fail;
        lock_d        = cur_lock;
        rsp_status_d  = STS_OK;
        rsp_balance_d = '0;

        if (!acct_ok) begin
            rsp_status_d = STS_BAD_ACCT;
        end else if (cur_lock) begin
            rsp_status_d = STS_LOCKED;
        end else if (pin_q != cur_pin) begin
            fail_d = fail_inc;
            if (fail_inc == FAIL_W'(MAX_TRIES)) begin
                lock_d       = 1'b1;
                rsp_status_d = STS_LOCKED;
            end else begin
                rsp_status_d = STS_BAD_PIN;
            end
        end else begin
            fail_d = '0;
            case (op_q)
                OP_WITHDRAW: begin
                    if (amt_q > cur_bal) begin
                        rsp_status_d = STS_INSUFF;
                    end else begin
                        bal_d = cur_bal - amt_q;
                    end
                end
                OP_DEPOSIT: begin
                    if (dep_sum[BAL_W]) begin
                        rsp_status_d = STS_OVERFLOW;
                    end else begin
                        bal_d = dep_sum[BAL_W-1:0];
                    end
                end
                default: ;
            endcase
            rsp_balance_d = bal_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            acct_q        <= '0;
            pin_q         <= '0;
            amt_q         <= '0;
            rsp_status_q  <= '0;
            rsp_balance_q <= '0;
            for (int i = 0; i < NUM_ACCTS; i++) begin
                bal_tbl_q[i]  <= BAL_W'(INIT_BALANCE);
                pin_tbl_q[i]  <= DEFAULT_PIN;
                fail_tbl_q[i] <= '0;
                lock_tbl_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;

            if (state_q == ST_IDLE && req_valid) begin
                op_q   <= req_op;
                acct_q <= req_acct;
                pin_q  <= req_pin;
                amt_q  <= req_amount;
            end

            if (state_q == ST_EXEC) begin
                rsp_status_q  <= rsp_status_d;
                rsp_balance_q <= rsp_balance_d;
                if (acct_ok) begin
                    bal_tbl_q[acct_q]  <= bal_d;
                    fail_tbl_q[acct_q] <= fail_d;
                    lock_tbl_q[acct_q] <= lock_d;
                end
            end

            // Placed after the EXEC update so a coincident unlock of the
            // same account wins for lock and fail count.
            for (int i = 0; i < NUM_ACCTS; i++) begin
                if (unlock && unlock_acct == ACCT_W'(i)) begin
                    fail_tbl_q[i] <= '0;
                    lock_tbl_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_atm_account_server.sv
// ----------------------------------------------------------------------------
// tb_atm_account_server
//
// Directed bench for atm_account_server with hand-computed expected values.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_atm_account_server;

    localparam logic [2:0] OK = 3'd0, BAD_PIN = 3'd1, LOCKED = 3'd2,
                           INSUFF = 3'd3, OVERFLOW = 3'd4;
    localparam logic [1:0] WD = 2'b00, DEP = 2'b01, BAL = 2'b10, VER = 2'b11;
    localparam logic [3:0] PIN_OK = 4'b1101, PIN_BAD = 4'b0000;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [1:0] req_acct;
    logic [3:0] req_pin;
    logic [7:0] req_amount;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] rsp_status;
    logic [7:0] rsp_balance;
    logic       unlock;
    logic [1:0] unlock_acct;

    int n_checks = 0;
    int n_errors = 0;

    atm_account_server dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_acct   (req_acct),
        .req_pin    (req_pin),
        .req_amount (req_amount),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_balance(rsp_balance),
        .unlock     (unlock),
        .unlock_acct(unlock_acct)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for req_ready at a falling edge.
    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!req_ready) chk({tag, "_ready_timeout"}, 0, 1);
    endtask

    // Full transaction: accept, check latency, check response, consume it.
    task automatic txn(input string tag, input logic [1:0] op, input logic [1:0] acct,
                       input logic [3:0] pin, input logic [7:0] amt,
                       input logic [2:0] exp_sts, input logic [7:0] exp_bal);
        wait_ready(tag);
        req_valid  = 1'b1;
        req_op     = op;
        req_acct   = acct;
        req_pin    = pin;
        req_amount = amt;
        @(negedge clk);
        req_valid  = 1'b0;
        req_op     = ~op;
        req_pin    = ~pin;
        req_amount = 8'hAA;
        chk({tag, "_valid_early"}, int'(rsp_valid), 0);
        @(negedge clk);
        chk({tag, "_valid"},   int'(rsp_valid), 1);
        chk({tag, "_status"},  int'(rsp_status), int'(exp_sts));
        chk({tag, "_balance"}, int'(rsp_balance), int'(exp_bal));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, int'(rsp_valid), 0);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_op      = 2'b00;
        req_acct    = 2'd0;
        req_pin     = 4'd0;
        req_amount  = 8'd0;
        rsp_ready   = 1'b0;
        unlock      = 1'b0;
        unlock_acct = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready",   int'(req_ready), 1);
        chk("rst_rsp_valid",   int'(rsp_valid), 0);
        chk("rst_rsp_status",  int'(rsp_status), 0);
        chk("rst_rsp_balance", int'(rsp_balance), 0);

        txn("a0_bal", BAL, 2'd0, PIN_OK, 8'd0, OK, 8'd50);

        txn("a1_wd20",  WD, 2'd1, PIN_OK, 8'd20, OK,     8'd30);
        txn("a1_wd31",  WD, 2'd1, PIN_OK, 8'd31, INSUFF, 8'd30);
        txn("a1_wd30",  WD, 2'd1, PIN_OK, 8'd30, OK,     8'd0);
        txn("a1_wd0",   WD, 2'd1, PIN_OK, 8'd0,  OK,     8'd0);

        txn("a2_dep200", DEP, 2'd2, PIN_OK, 8'd200, OK,       8'd250);
        txn("a2_dep6",   DEP, 2'd2, PIN_OK, 8'd6,   OVERFLOW, 8'd250);
        txn("a2_dep5",   DEP, 2'd2, PIN_OK, 8'd5,   OK,       8'd255);

        txn("a3_bad1",  VER, 2'd3, PIN_BAD, 8'd0, BAD_PIN, 8'd0);
        txn("a3_bad2",  VER, 2'd3, PIN_BAD, 8'd0, BAD_PIN, 8'd0);
        txn("a3_bad3",  VER, 2'd3, PIN_BAD, 8'd0, LOCKED,  8'd0);
        txn("a3_lockd", VER, 2'd3, PIN_OK,  8'd0, LOCKED,  8'd0);
        unlock      = 1'b1;
        unlock_acct = 2'd3;
        @(negedge clk);
        unlock      = 1'b0;
        txn("a3_unlk",  VER, 2'd3, PIN_OK,  8'd0, OK, 8'd50);
        // Fail count was cleared by unlock: one bad PIN is only BAD_PIN.
        txn("a3_bad_after", VER, 2'd3, PIN_BAD, 8'd0, BAD_PIN, 8'd0);

        // Backpressure: response held 5 cycles while a new request waits.
        wait_ready("hold");
        req_valid = 1'b1;
        req_op    = BAL;
        req_acct  = 2'd0;
        req_pin   = PIN_OK;
        @(negedge clk);
        req_op     = WD;
        req_amount = 8'd10;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid",   int'(rsp_valid), 1);
            chk("hold_status",  int'(rsp_status), int'(OK));
            chk("hold_balance", int'(rsp_balance), 50);
            chk("hold_ready",   int'(req_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hold_valid_drop", int'(rsp_valid), 0);
        chk("hold_ready_back", int'(req_ready), 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("hold_next_accepted", int'(req_ready), 0);
        @(negedge clk);
        chk("hold_next_valid",   int'(rsp_valid), 1);
        chk("hold_next_status",  int'(rsp_status), int'(OK));
        chk("hold_next_balance", int'(rsp_balance), 40);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset during EXEC of a withdraw: no response, table restored.
        wait_ready("rst_exec");
        req_valid  = 1'b1;
        req_op     = WD;
        req_acct   = 2'd0;
        req_pin    = PIN_OK;
        req_amount = 8'd10;
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_exec_valid", int'(rsp_valid), 0);
        chk("rst_exec_ready", int'(req_ready), 1);
        repeat (2) @(negedge clk);
        chk("rst_exec_valid_later", int'(rsp_valid), 0);
        txn("rst_exec_bal", BAL, 2'd0, PIN_OK, 8'd0, OK, 8'd50);
        txn("rst_a1_bal",   BAL, 2'd1, PIN_OK, 8'd0, OK, 8'd50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/atm_account_server.md
Name: atm_account_server

Overview:
- Bank-side responder to the ATM controller's transaction requests.
- Holds a small account table: PIN, 8-bit balance, consecutive-bad-PIN counter and lock flag per account.
- Authenticates and executes withdraw, deposit, balance and verify requests, one at a time.
- Uses a valid/ready request channel and a valid/ready response channel.

Parameters:
- NUM_ACCTS, 4, number of accounts; must be ≤ 2^ACCT_W.
- ACCT_W, 2, account index width.
- BAL_W, 8, balance and amount width.
- PIN_W, 4, PIN width.
- MAX_TRIES, 3, consecutive bad PINs that lock an account.
- INIT_BALANCE, 50, balance of every account after reset.
- DEFAULT_PIN, 4'b1101, PIN of every account after reset.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  server can accept a request.
- req_op  in  2  00 withdraw, 01 deposit, 10 balance, 11 verify PIN.
- req_acct  in  ACCT_W  account index.
- req_pin  in  PIN_W  PIN supplied by the customer.
- req_amount  in  BAL_W  withdraw/deposit amount; ignored for ops 10 and 11.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  ATM consumes the response.
- rsp_status  out  3  0 OK, 1 BAD_PIN, 2 LOCKED, 3 INSUFFICIENT, 4 OVERFLOW, 5 BAD_ACCT.
- rsp_balance  out  BAL_W  account balance after the operation; 0 unless status is OK, INSUFFICIENT or OVERFLOW.
- unlock  in  1  single-cycle admin pulse that clears the lock for unlock_acct.
- unlock_acct  in  ACCT_W  account to unlock.

Behaviour:
- Reset (rst high at a rising edge):
  - Every account: balance = INIT_BALANCE, pin = DEFAULT_PIN, fail_cnt = 0, locked = 0.
  - State = IDLE; rsp_valid = 0, rsp_status = 0, rsp_balance = 0.
  - Reset overrides everything; an in-flight request is dropped with no table update and no response.
- FSM:
  - IDLE → EXEC → RESP → IDLE.
  - req_ready = 1 only in IDLE, and is 1 in the first cycle after reset.
- IDLE: on req_valid && req_ready, register op, acct, pin and amount; go to EXEC. Table unchanged.
- EXEC (exactly one cycle): evaluate checks in this priority order; the table updates at the end of EXEC.
  1. acct ≥ NUM_ACCTS → BAD_ACCT; no table change.
  2. locked → LOCKED; fail_cnt unchanged; balance not reported.
  3. pin mismatch → fail_cnt += 1.
     - If the new fail_cnt == MAX_TRIES: set locked, status LOCKED.
     - Otherwise: status BAD_PIN.
  4. pin match → fail_cnt = 0, then execute the op:
     - withdraw: amount > balance → INSUFFICIENT, balance unchanged. Otherwise balance −= amount, OK. Amount 0 is OK with no change.
     - deposit: balance + amount > 2^BAL_W − 1 → OVERFLOW, balance unchanged (no wrap). Otherwise balance += amount, OK. Compute the sum BAL_W+1 wide.
     - balance, verify: OK, table unchanged.
- RESP:
  - rsp_valid = 1 from the edge ending EXEC, i.e. two edges after the accept edge.
  - rsp_status and rsp_balance are registered and held stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE at that edge. rsp_valid drops the next cycle; the next request can be accepted the cycle after.
  - Throughput: one transaction per 3 cycles minimum.
- unlock:
  - Sampled every cycle: clears locked and fail_cnt of unlock_acct. Out-of-range index is ignored.
  - If it coincides with the EXEC update of the same account, unlock wins for locked and fail_cnt; balance still follows EXEC.
- req_* may change freely outside the accept cycle; only the registered copy is used.

Test Plan:
- Reset; acct 0, op 10, pin 1101 → rsp OK, balance 50, rsp_valid 2 edges after accept.
- Acct 1 withdraw 20 with pin 1101 → OK, 30. Then withdraw 31 → INSUFFICIENT, 30. Then withdraw 30 → OK, 0.
- Acct 2 deposit 200 → OK, 250. Then deposit 6 → OVERFLOW, 250. Then deposit 5 → OK, 255.
- Acct 3, bad pin 0000 twice → BAD_PIN, BAD_PIN. Third bad pin → LOCKED. Correct pin → LOCKED. Pulse unlock for acct 3, then correct pin op 11 → OK, 50.
- Hold rsp_ready low 5 cycles → rsp_valid, status and balance stable, req_ready 0, new req_valid ignored. Release → one response consumed, next request accepted.
- Assert rst during EXEC of a withdraw 10 on acct 0 → no response; subsequent balance query → 50.
